// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the two-requester memory arbiter.
//   state_e     : arbiter FSM states (idle, wait cycles, response pulse)
//   GNT_I/GNT_D : grant encoding (instruction side / data side)
//   BITS_DEF, LATENCY_DEF : default data/address width and wait cycles
package mem_pkg;

  localparam int BITS_DEF    = 32;
  localparam int LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: two-way round-robin choice between the I and D requesters.
//   i_req, d_req : pending requests
//   last_grant   : side granted most recently
//   grant        : chosen side (GNT_I / GNT_D), meaningful when valid=1
//   valid        : at least one request is pending
module mem_rr_pick
  import mem_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = i_req | d_req;
    // On a conflict the side that did not win last time goes first.
    if (i_req && d_req) begin
      grant = ~last_grant;
    end else if (d_req) begin
      grant = GNT_D;
    end else begin
      grant = GNT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between an I-side
// (read-only) and a D-side (read/write) requester. Each access is granted
// in IDLE, held for LATENCY wait cycles in BUSY, and acknowledged with a
// one-cycle ready pulse in RESP.
//   clk, rst                      : clock, asynchronous active-high reset
//   i_req/i_addr -> i_ready/i_rdata : instruction fetch port
//   d_req/d_wen/d_addr/d_wdata -> d_ready/d_rdata : data port
//   mem_wen/mem_a/mem_d <- mem_q  : memory port (combinational read,
//                                   write on clock edge)
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int BITS    = BITS_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [BITS-1:0] i_addr,
  output logic            i_ready,
  output logic [BITS-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_wen,
  input  logic [BITS-1:0] d_addr,
  input  logic [BITS-1:0] d_wdata,
  output logic            d_ready,
  output logic [BITS-1:0] d_rdata,
  output logic            mem_wen,
  output logic [BITS-1:0] mem_a,
  output logic [BITS-1:0] mem_d,
  input  logic [BITS-1:0] mem_q
);

  localparam int CW = $clog2(LATENCY + 1);

  state_e          state_q,   state_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic            last_q,    last_d;
  logic            gnt_q,     gnt_d;
  logic            wen_q,     wen_d;
  logic [BITS-1:0] addr_q,    addr_d;
  logic [BITS-1:0] wdata_q,   wdata_d;
  logic [BITS-1:0] i_rdata_q, i_rdata_d;
  logic [BITS-1:0] d_rdata_q, d_rdata_d;

  logic            pick_grant;
  logic            pick_valid;
  logic            busy;
  logic [BITS-1:0] capture;

  mem_rr_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_q),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  assign busy = (state_q == ST_BUSY);

  // A write completes with its own data; memory would still show the old
  // word during the final cycle because the write lands on the closing edge.
  assign capture = wen_q ? wdata_q : mem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_grant;
          last_d  = pick_grant;
          if (pick_grant == GNT_D) begin
            addr_d  = d_addr;
            wen_d   = d_wen;
            wdata_d = d_wdata;
          end else begin
            addr_d  = i_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
          end
          cnt_d   = CW'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          if (gnt_q == GNT_D) begin
            d_rdata_d = capture;
          end else begin
            i_rdata_d = capture;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= GNT_D;
      gnt_q     <= GNT_I;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Write strobe only in the last wait cycle so the memory sees exactly one
  // write edge per access.
  assign mem_wen = busy && wen_q && (cnt_q == '0);
  assign mem_a   = busy ? addr_q  : '0;
  assign mem_d   = busy ? wdata_q : '0;

  assign i_ready = (state_q == ST_RESP) && (gnt_q == GNT_I);
  assign d_ready = (state_q == ST_RESP) && (gnt_q == GNT_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
